// File: rtl/collision_detector.sv
// collision_detector
//
// Frame-based collision detector for the game controller. During each VGA
// frame it watches the per-pixel draw requests of the ball, the good/bad
// obstacles and the bottom border, and remembers any ball overlap in sticky
// per-frame flags. At every startOfFrame the flags of the frame just finished
// are evaluated, and a registered single-cycle pulse group is issued in the
// following clock.
//
// Bottom contact has priority: it suppresses the obstacle outputs for that
// frame. Obstacle reports can be rate-limited by a cooldown FSM so that one
// continuous contact yields a single score event.
//
// Build option:
//   COLLISION_COOLDOWN_EN  defined   : ARMED/COOLDOWN FSM with an 8-bit
//                                      frame counter loaded with
//                                      COOLDOWN_FRAMES after each report.
//                          undefined : always armed, every obstacle frame
//                                      is reported; COOLDOWN_FRAMES unused.
//
// Parameters:
//   COOLDOWN_FRAMES            frames of obstacle suppression after a report
//                              (1..255).
// Ports:
//   clk                        pixel clock
//   resetN                     asynchronous active-low reset
//   startOfFrame               1-cycle pulse at the first pixel of a frame
//   pause                      game paused: flags held clear, FSM frozen
//   reset_level_pulse          1-cycle level restart: clear flags, re-arm
//   ballDR                     ball draws the current pixel
//   obstacleGoodDR             good obstacle draws the current pixel
//   obstacleBadDR              bad obstacle draws the current pixel
//   bottomDR                   bottom border draws the current pixel
//   collisionBallObstacle      pulse: ball hit an obstacle last frame
//   collisionBallObstacleGood  qualifier: the hit included a good obstacle
//   collisionBallObstacleBad   qualifier: the hit included a bad obstacle
//   collisionBallBottom        pulse: ball reached the bottom last frame

module collision_detector #(
  parameter int unsigned COOLDOWN_FRAMES = 8
) (
  input  logic clk,
  input  logic resetN,
  input  logic startOfFrame,
  input  logic pause,
  input  logic reset_level_pulse,
  input  logic ballDR,
  input  logic obstacleGoodDR,
  input  logic obstacleBadDR,
  input  logic bottomDR,
  output logic collisionBallObstacle,
  output logic collisionBallObstacleGood,
  output logic collisionBallObstacleBad,
  output logic collisionBallBottom
);

  // Reject an out-of-range cooldown at elaboration time.
  if (COOLDOWN_FRAMES < 1 || COOLDOWN_FRAMES > 255) begin : gen_bad_cooldown
    $error("collision_detector: COOLDOWN_FRAMES must be in 1..255");
  end

  // ---------------------------------------------------------------------------
  // Per-pixel overlap detection
  // ---------------------------------------------------------------------------
  logic hit_good, hit_bad, hit_bottom;

  assign hit_good   = ballDR & obstacleGoodDR;
  assign hit_bad    = ballDR & obstacleBadDR;
  assign hit_bottom = ballDR & bottomDR;

  // A frame boundary only counts when neither a level restart nor pause
  // overrides it.
  logic evaluate;
  assign evaluate = startOfFrame & ~pause & ~reset_level_pulse;

  // ---------------------------------------------------------------------------
  // Sticky per-frame flags
  // ---------------------------------------------------------------------------
  logic acc_good_q,   acc_good_d;
  logic acc_bad_q,    acc_bad_d;
  logic acc_bottom_q, acc_bottom_d;

  always_comb begin
    acc_good_d   = acc_good_q;
    acc_bad_d    = acc_bad_q;
    acc_bottom_d = acc_bottom_q;
    if (reset_level_pulse || pause) begin
      acc_good_d   = 1'b0;
      acc_bad_d    = 1'b0;
      acc_bottom_d = 1'b0;
    end else if (startOfFrame) begin
      // Old frame is cleared; the boundary pixel itself opens the new frame.
      acc_good_d   = hit_good;
      acc_bad_d    = hit_bad;
      acc_bottom_d = hit_bottom;
    end else begin
      acc_good_d   = acc_good_q   | hit_good;
      acc_bad_d    = acc_bad_q    | hit_bad;
      acc_bottom_d = acc_bottom_q | hit_bottom;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      acc_good_q   <= 1'b0;
      acc_bad_q    <= 1'b0;
      acc_bottom_q <= 1'b0;
    end else begin
      acc_good_q   <= acc_good_d;
      acc_bad_q    <= acc_bad_d;
      acc_bottom_q <= acc_bottom_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Report qualification
  // ---------------------------------------------------------------------------
  logic armed;
  logic obstacle_report;

  // Bottom contact discards any obstacle overlap of the same frame.
  assign obstacle_report = evaluate & ~acc_bottom_q & (acc_good_q | acc_bad_q) & armed;

`ifdef COLLISION_COOLDOWN_EN
  // ---------------------------------------------------------------------------
  // Cooldown FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [0:0] {StArmed, StCooldown} state_e;

  localparam logic [7:0] CooldownLoad = 8'(COOLDOWN_FRAMES);

  state_e     state_q, state_d;
  logic [7:0] cnt_q,   cnt_d;

  assign armed = (state_q == StArmed);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (reset_level_pulse) begin
      state_d = StArmed;
      cnt_d   = 8'd0;
    end else if (evaluate) begin
      unique case (state_q)
        StArmed: begin
          if (obstacle_report) begin
            state_d = StCooldown;
            cnt_d   = CooldownLoad;
          end
        end
        StCooldown: begin
          // The frame on which the count runs out is still suppressed; the
          // <= 1 test also keeps the counter from wrapping below zero.
          if (cnt_q > 8'd1) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            cnt_d   = 8'd0;
            state_d = StArmed;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= StArmed;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  assign armed = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Registered output pulses
  // ---------------------------------------------------------------------------
  logic obstacle_q, obstacle_d;
  logic good_q,     good_d;
  logic bad_q,      bad_d;
  logic bottom_q,   bottom_d;

  always_comb begin
    obstacle_d = 1'b0;
    good_d     = 1'b0;
    bad_d      = 1'b0;
    bottom_d   = 1'b0;
    if (evaluate) begin
      bottom_d   = acc_bottom_q;
      obstacle_d = obstacle_report;
      good_d     = obstacle_report & acc_good_q;
      bad_d      = obstacle_report & acc_bad_q;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      obstacle_q <= 1'b0;
      good_q     <= 1'b0;
      bad_q      <= 1'b0;
      bottom_q   <= 1'b0;
    end else begin
      obstacle_q <= obstacle_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      bottom_q   <= bottom_d;
    end
  end

  assign collisionBallObstacle     = obstacle_q;
  assign collisionBallObstacleGood = good_q;
  assign collisionBallObstacleBad  = bad_q;
  assign collisionBallBottom       = bottom_q;

endmodule

// File: tb/tb_collision_detector.sv
// Self-checking bench for collision_detector: directed vector table, a few
// multi-cycle sequences, and random stimulus against a frame-level model.
// Outputs are packed as {Obstacle, Good, Bad, Bottom}.

module tb_collision_detector;

  localparam int unsigned Cd = 2;
`ifdef COLLISION_COOLDOWN_EN
  localparam bit CdEn = 1'b1;
`else
  localparam bit CdEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetN;
  logic startOfFrame, pause, reset_level_pulse;
  logic ballDR, obstacleGoodDR, obstacleBadDR, bottomDR;
  logic collisionBallObstacle, collisionBallObstacleGood;
  logic collisionBallObstacleBad, collisionBallBottom;

  collision_detector #(.COOLDOWN_FRAMES(Cd)) dut (
    .clk                       (clk),
    .resetN                    (resetN),
    .startOfFrame              (startOfFrame),
    .pause                     (pause),
    .reset_level_pulse         (reset_level_pulse),
    .ballDR                    (ballDR),
    .obstacleGoodDR            (obstacleGoodDR),
    .obstacleBadDR             (obstacleBadDR),
    .bottomDR                  (bottomDR),
    .collisionBallObstacle     (collisionBallObstacle),
    .collisionBallObstacleGood (collisionBallObstacleGood),
    .collisionBallObstacleBad  (collisionBallObstacleBad),
    .collisionBallBottom       (collisionBallBottom)
  );

  always #5 clk = ~clk;

  logic [3:0] dut_out;
  assign dut_out = {collisionBallObstacle, collisionBallObstacleGood,
                    collisionBallObstacleBad, collisionBallBottom};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Frame-level reference: evaluations are numbered; after a report at
  // evaluation k the next reportable evaluation is k + Cd + 1.
  bit         m_good, m_bad, m_bot;
  int         eval_cnt, next_ok;
  logic [3:0] exp_out;

  function automatic void model_reset();
    m_good = 0; m_bad = 0; m_bot = 0;
    eval_cnt = 0; next_ok = 0; exp_out = 4'b0000;
  endfunction

  function automatic void model_step(input logic sof, p, rl, ball, g, b, bot);
    bit hg, hb, hbot;
    hg = ball & g; hb = ball & b; hbot = ball & bot;
    exp_out = 4'b0000;
    if (rl) begin
      m_good = 0; m_bad = 0; m_bot = 0;
      next_ok = 0;
    end else if (p) begin
      m_good = 0; m_bad = 0; m_bot = 0;
    end else if (sof) begin
      eval_cnt++;
      if (m_bot) begin
        exp_out = 4'b0001;
      end else if ((m_good || m_bad) && (!CdEn || eval_cnt >= next_ok)) begin
        exp_out = {1'b1, m_good, m_bad, 1'b0};
        next_ok = eval_cnt + int'(Cd) + 1;
      end
      m_good = hg; m_bad = hb; m_bot = hbot;
    end else begin
      m_good |= hg; m_bad |= hb; m_bot |= hbot;
    end
  endfunction

  // One clock: drive, clock edge, update model, sample 1 time unit later.
  task automatic step(input logic sof, p, rl, ball, g, b, bot);
    startOfFrame = sof; pause = p; reset_level_pulse = rl;
    ballDR = ball; obstacleGoodDR = g; obstacleBadDR = b; bottomDR = bot;
    @(posedge clk);
    model_step(sof, p, rl, ball, g, b, bot);
    #1;
    chk("model", dut_out, exp_out);
  endtask

  task automatic idle();     step(0, 0, 0, 0, 0, 0, 0); endtask
  task automatic hit_good(); step(0, 0, 0, 1, 1, 0, 0); endtask
  task automatic sof();      step(1, 0, 0, 0, 0, 0, 0); endtask
  task automatic rlevel();   step(0, 0, 1, 0, 0, 0, 0); endtask

  typedef struct packed {
    logic sof, p, rl, ball, g, b, bot;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic sof, p, rl, ball, g, b, bot, input logic [3:0] e);
    vec_t r;
    r.sof = sof; r.p = p; r.rl = rl; r.ball = ball; r.g = g; r.b = b; r.bot = bot; r.exp = e;
    return r;
  endfunction

  logic cd_exp[6];
  logic pz_exp[3];

  initial begin
    // Good hit over 3 pixels
    vecs.push_back(v(1,0,0,0,0,0,0, 4'b0000));
    vecs.push_back(v(0,0,0,1,1,0,0, 4'b0000));
    vecs.push_back(v(0,0,0,1,1,0,0, 4'b0000));
    vecs.push_back(v(0,0,0,1,1,0,0, 4'b0000));
    vecs.push_back(v(0,0,0,0,0,0,0, 4'b0000));
    vecs.push_back(v(1,0,0,0,0,0,0, 4'b1100));
    vecs.push_back(v(0,0,0,0,0,0,0, 4'b0000));
    // Bottom priority over good and bad
    vecs.push_back(v(0,0,1,0,0,0,0, 4'b0000));
    vecs.push_back(v(0,0,0,1,1,1,1, 4'b0000));
    vecs.push_back(v(1,0,0,0,0,0,0, 4'b0001));
    vecs.push_back(v(0,0,0,0,0,0,0, 4'b0000));
    // Good and bad together
    vecs.push_back(v(0,0,0,1,1,1,0, 4'b0000));
    vecs.push_back(v(1,0,0,0,0,0,0, 4'b1110));
    vecs.push_back(v(0,0,0,0,0,0,0, 4'b0000));
    // Level restart coincident with startOfFrame
    vecs.push_back(v(0,0,1,0,0,0,0, 4'b0000));
    vecs.push_back(v(0,0,0,1,1,0,0, 4'b0000));
    vecs.push_back(v(1,0,1,0,0,0,0, 4'b0000));
    vecs.push_back(v(0,0,0,0,0,0,0, 4'b0000));
    vecs.push_back(v(0,0,0,1,1,0,0, 4'b0000));
    vecs.push_back(v(1,0,0,0,0,0,0, 4'b1100));
    // Overlap only on the boundary pixel belongs to the new frame
    vecs.push_back(v(0,0,1,0,0,0,0, 4'b0000));
    vecs.push_back(v(1,0,0,1,1,0,0, 4'b0000));
    vecs.push_back(v(0,0,0,0,0,0,0, 4'b0000));
    vecs.push_back(v(1,0,0,0,0,0,0, 4'b1100));
    // Pause: overlap discarded, startOfFrame ignored
    vecs.push_back(v(0,0,1,0,0,0,0, 4'b0000));
    vecs.push_back(v(0,1,0,1,1,0,0, 4'b0000));
    vecs.push_back(v(0,0,0,0,0,0,0, 4'b0000));
    vecs.push_back(v(1,0,0,0,0,0,0, 4'b0000));
    vecs.push_back(v(0,0,0,1,1,0,0, 4'b0000));
    vecs.push_back(v(1,1,0,0,0,0,0, 4'b0000));
    vecs.push_back(v(1,0,0,0,0,0,0, 4'b0000));

    if (CdEn) begin
      cd_exp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      pz_exp = '{1'b0, 1'b0, 1'b1};
    end else begin
      cd_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      pz_exp = '{1'b1, 1'b1, 1'b1};
    end

    resetN = 1'b0;
    startOfFrame = 0; pause = 0; reset_level_pulse = 0;
    ballDR = 0; obstacleGoodDR = 0; obstacleBadDR = 0; bottomDR = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset", dut_out, 4'b0000);
    resetN = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].sof, vecs[i].p, vecs[i].rl, vecs[i].ball, vecs[i].g, vecs[i].b, vecs[i].bot);
      chk($sformatf("vec%0d", i), dut_out, vecs[i].exp);
    end

    // Cooldown: a good overlap in each of 6 frames
    rlevel();
    for (int f = 0; f < 6; f++) begin
      hit_good();
      idle();
      sof();
      chk($sformatf("cooldown%0d", f), {3'b000, collisionBallObstacle}, {3'b000, cd_exp[f]});
    end

    // Counter frozen across 3 paused frames
    rlevel();
    hit_good();
    sof();
    chk("pause_report", dut_out, 4'b1100);
    for (int f = 0; f < 3; f++) begin
      step(0, 1, 0, 1, 1, 0, 0);
      step(1, 1, 0, 1, 1, 0, 0);
      chk($sformatf("paused%0d", f), dut_out, 4'b0000);
    end
    for (int f = 0; f < 3; f++) begin
      hit_good();
      sof();
      chk($sformatf("after_pause%0d", f), {3'b000, collisionBallObstacle}, {3'b000, pz_exp[f]});
    end

    // Async reset during a pulse; partial frame is discarded
    rlevel();
    hit_good();
    step(1, 0, 0, 1, 1, 0, 0);
    chk("pre_reset_pulse", dut_out, 4'b1100);
    #2;
    resetN = 1'b0;
    #1;
    chk("async_reset", dut_out, 4'b0000);
    model_reset();
    #2;
    resetN = 1'b1;
    idle();
    sof();
    chk("partial_discard", dut_out, 4'b0000);

    // Random stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 6) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/collision_detector.md
# collision_detector

Frame-based collision detector feeding the game controller. It watches per-pixel drawing requests from the ball, obstacle and bottom-border renderers during each VGA frame and accumulates any overlaps. At each start-of-frame it issues single-cycle collision pulses for the frame just completed. Obstacle pulses are rate-limited so that one continuous contact produces only one score event.

## Interface
Parameters:
- COOLDOWN_FRAMES, default 8: frames of obstacle-report suppression after a reported obstacle hit; legal range 1..255.

Ports:
- clk  in  1  pixel clock.
- resetN  in  1  reset, asynchronous, active-low.
- startOfFrame  in  1  single-cycle pulse at the first pixel of each frame.
- pause  in  1  game paused; from the game controller.
- reset_level_pulse  in  1  single-cycle level restart; from the game controller.
- ballDR  in  1  ball draws the current pixel.
- obstacleGoodDR  in  1  a good obstacle draws the current pixel.
- obstacleBadDR  in  1  a bad obstacle draws the current pixel.
- bottomDR  in  1  bottom border draws the current pixel.
- collisionBallObstacle  out  1  pulse: the ball hit any obstacle last frame.
- collisionBallObstacleGood  out  1  pulse, qualifier: the hit included a good obstacle.
- collisionBallObstacleBad  out  1  pulse, qualifier: the hit included a bad obstacle.
- collisionBallBottom  out  1  pulse: the ball reached the bottom last frame.

## Operation
- Per-frame sticky flags accGood, accBad, accBottom are set in any cycle where ballDR is high together with obstacleGoodDR, obstacleBadDR or bottomDR respectively.
- On startOfFrame the accumulated flags are evaluated, and every flag is cleared in the same cycle.
  - The pixel sampled in the startOfFrame cycle is accumulated into the new frame, after the clear.
- Priority rule: if accBottom is set, only collisionBallBottom pulses. Obstacle outputs stay low and the obstacle flags are discarded.
- Otherwise, if accGood or accBad is set and the FSM is ARMED:
  - collisionBallObstacle pulses.
  - The Good and Bad qualifiers copy accGood and accBad. Both may be 1 together.
- The FSM has two states:
  - ARMED: an obstacle report moves the FSM to COOLDOWN and loads cnt = COOLDOWN_FRAMES.
  - COOLDOWN: cnt decrements on each startOfFrame. Obstacle hits are discarded. When cnt reaches 0, the FSM returns to ARMED; that frame's evaluation itself is still suppressed.
  - Bottom reports are never suppressed.
- pause = 1:
  - Flags are held clear and no pulses are issued.
  - cnt and the state are frozen.
  - A startOfFrame arriving while paused is ignored.
- reset_level_pulse = 1: flags are cleared, the FSM goes to ARMED, cnt = 0, and no pulse is issued that cycle. This input wins over a simultaneous startOfFrame.
- Width: cnt is 8 bits, unsigned, and never wraps below 0.

## Timing
- Reset: all outputs 0, flags 0, FSM ARMED, cnt 0.
- Latency: a pulse is asserted in the cycle after the startOfFrame cycle and lasts exactly 1 clk. The outputs are registered.
- All qualifiers are coincident with their collisionBallObstacle pulse.
- At most one pulse group per frame. The game controller samples the pulses when it is unpaused.
- Reset asserted mid-frame discards the partial frame. The first evaluation after release happens at the first startOfFrame, and it covers only the cycles after release.

## Configuration
- COLLISION_COOLDOWN_EN defined: COOLDOWN FSM behaviour as above.
- Not defined:
  - The FSM is permanently ARMED and cnt is removed.
  - Every frame with an obstacle overlap (and no bottom overlap) produces a collisionBallObstacle pulse.
  - COOLDOWN_FRAMES is ignored.

## Test plan
- Good hit: reset; ballDR and obstacleGoodDR are high together for 3 pixels in frame 1 → 1-cycle pulse after the next startOfFrame with Obstacle=1, Good=1, Bad=0; all outputs 0 otherwise.
- Simultaneous hits and priority:
  - Ball overlaps good, bad and bottom in one frame → only Bottom=1.
  - Good and bad overlap without bottom → Obstacle=Good=Bad=1.
- Cooldown with COOLDOWN_FRAMES=2 and macro defined: a good overlap every frame for 6 frames → obstacle pulses at evaluations 1 and 4 only. Without the macro → pulses at all 6.
- Pause: overlap while pause=1, then unpause → no pulse. cnt is unchanged across 3 paused frames.
- reset_level_pulse in the same cycle as startOfFrame, with accGood set → no pulse; FSM ARMED; next frame's overlap is reported normally.
- Frame boundary: overlap only in the startOfFrame cycle → reported at the following startOfFrame, not the current one. Async reset mid-frame → outputs 0 immediately.
